// File: rtl/calc_pkg.sv
// Shared op-code constants and FSM state encoding for the parameterised calculator.
package calc_pkg;

   localparam int unsigned OPW = 3;
   localparam int unsigned CSW = 4;

   localparam logic [OPW-1:0] OP_ADD = 3'd0;
   localparam logic [OPW-1:0] OP_SUB = 3'd1;
   localparam logic [OPW-1:0] OP_AND = 3'd2;
   localparam logic [OPW-1:0] OP_OR  = 3'd3;
   localparam logic [OPW-1:0] OP_XOR = 3'd4;
   localparam logic [OPW-1:0] OP_SHL = 3'd5;
   localparam logic [OPW-1:0] OP_SHR = 3'd6;
   localparam logic [OPW-1:0] OP_MUL = 3'd7;

   // Codes double as the 7-segment state display value
   typedef enum logic [CSW-1:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_EXEC = 4'd2,
      S_MUL  = 4'd3,
      S_WB   = 4'd4,
      S_DONE = 4'd5
   } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU plus one shift-add multiply step (MSB-first).
module calc_alu
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic [OPW-1:0]     op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] acc,
   input  logic               mbit,
   output logic [WIDTH-1:0]   result,
   output logic               carry,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;

   assign sum      = {1'b0, a} + {1'b0, b};
   assign shamt    = b[SHW-1:0];
   assign acc_next = (acc << 1) + (mbit ? {{WIDTH{1'b0}}, a} : '0);

   // For MUL the result reflects the accumulator after this step
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: result = a << shamt;
         OP_SHR: result = a >> shamt;
         OP_MUL: begin
            result = acc_next[WIDTH-1:0];
            carry  = |acc_next[2*WIDTH-1:WIDTH];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/calculator_param.sv
// Multi-cycle calculator: operand latch, ALU/iterative multiply, registered write-back.
module calculator_param
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic             flag_c,
   output logic             flag_z,
   output logic             busy,
   output logic             done,
   output logic [3:0]       CS
);

   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   state_e             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [OPW-1:0]     opr_q;
   logic [WIDTH-1:0]   r_q;
   logic               rc_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNTW-1:0]    cnt_q;

   logic               mbit;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_carry;
   logic [2*WIDTH-1:0] acc_next;

   // Multiplier bit for this step: counter WIDTH..1 selects B[WIDTH-1]..B[0]
   assign mbit = |(b_q & (WIDTH'(1) << (cnt_q - CNTW'(1))));
   assign CS   = state;

   calc_alu #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_alu (
      .op       (opr_q),
      .a        (a_q),
      .b        (b_q),
      .acc      (acc_q),
      .mbit     (mbit),
      .result   (alu_result),
      .carry    (alu_carry),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         opr_q  <= '0;
         r_q    <= '0;
         rc_q   <= 1'b0;
         acc_q  <= '0;
         cnt_q  <= '0;
         out    <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  a_q   <= in1;
                  b_q   <= in2;
                  opr_q <= op;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: state <= S_EXEC;
            S_EXEC: begin
               if (opr_q == OP_MUL) begin
                  acc_q <= '0;
                  cnt_q <= CNTW'(WIDTH);
                  state <= S_MUL;
               end else begin
                  r_q   <= alu_result;
                  rc_q  <= alu_carry;
                  state <= S_WB;
               end
            end
            S_MUL: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q - CNTW'(1);
               if (cnt_q <= CNTW'(1)) begin
                  r_q   <= alu_result;
                  rc_q  <= alu_carry;
                  state <= S_WB;
               end
            end
            S_WB: begin
               out    <= r_q;
               flag_c <= rc_q;
               flag_z <= (r_q == '0);
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calculator_param.sv
// Directed self-checking bench for calculator_param at WIDTH=8.
module tb_calculator_param;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic [2:0] op;
   logic [7:0] in1;
   logic [7:0] in2;
   logic [7:0] out;
   logic       flag_c;
   logic       flag_z;
   logic       busy;
   logic       done;
   logic [3:0] CS;

   int checks = 0;
   int errors = 0;

   calculator_param #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .go     (go),
      .op     (op),
      .in1    (in1),
      .in2    (in2),
      .out    (out),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .busy   (busy),
      .done   (done),
      .CS     (CS)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic start_go(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      go  = 1'b1;
      op  = o;
      in1 = a;
      in2 = b;
   endtask

   // Called at the negedge where go was raised; waits for done and checks the result
   task automatic finish_op(input string tag, input logic [7:0] eo, input logic ec,
                            input logic ez, input int elat);
      int lat;
      lat = 0;
      @(negedge clk);
      go = 1'b0;
      check({tag, " busy"}, 32'(busy), 32'(1));
      check({tag, " cs_load"}, 32'(CS), 32'(1));
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " out"}, 32'(out), 32'(eo));
      check({tag, " flag_c"}, 32'(flag_c), 32'(ec));
      check({tag, " flag_z"}, 32'(flag_z), 32'(ez));
      check({tag, " cs_done"}, 32'(CS), 32'(5));
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done), 32'(0));
      check({tag, " idle"}, 32'(busy), 32'(0));
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic ec,
                         input logic ez, input int elat);
      @(negedge clk);
      start_go(o, a, b);
      finish_op(tag, eo, ec, ez, elat);
   endtask

   initial begin
      int pulses;
      int lat;
      int d2;
      logic [7:0] got_out;
      logic       got_c;

      rst = 1'b0;
      go  = 1'b0;
      op  = '0;
      in1 = '0;
      in2 = '0;
      #12;
      check("rst out", 32'(out), 32'(0));
      check("rst flag_c", 32'(flag_c), 32'(0));
      check("rst flag_z", 32'(flag_z), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst done", 32'(done), 32'(0));
      check("rst cs", 32'(CS), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 4);
      run_op("sub_5_5",     OP_SUB, 8'd5,   8'd5,   8'd0,   1'b0, 1'b1, 4);
      run_op("sub_3_5",     OP_SUB, 8'd3,   8'd5,   8'd254, 1'b1, 1'b0, 4);
      run_op("mul_20_15",   OP_MUL, 8'd20,  8'd15,  8'd44,  1'b1, 1'b0, 12);
      run_op("mul_12_10",   OP_MUL, 8'd12,  8'd10,  8'd120, 1'b0, 1'b0, 12);
      run_op("mul_255_255", OP_MUL, 8'hFF,  8'hFF,  8'h01,  1'b1, 1'b0, 12);
      run_op("mul_0_255",   OP_MUL, 8'd0,   8'hFF,  8'd0,   1'b0, 1'b1, 12);
      run_op("shl_81_9",    OP_SHL, 8'h81,  8'h09,  8'h02,  1'b0, 1'b0, 4);
      run_op("shr_80_7",    OP_SHR, 8'h80,  8'd7,   8'h01,  1'b0, 1'b0, 4);
      run_op("shl_by_0",    OP_SHL, 8'h5A,  8'h08,  8'h5A,  1'b0, 1'b0, 4);
      run_op("and",         OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 4);
      run_op("or",          OP_OR,  8'hA0,  8'h05,  8'hA5,  1'b0, 1'b0, 4);
      run_op("xor_zero",    OP_XOR, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1, 4);
      run_op("add_wrap",    OP_ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1, 4);

      // go with new operands during EXEC, MUL and DONE must be ignored
      @(negedge clk);
      start_go(OP_MUL, 8'd20, 8'd15);
      pulses  = 0;
      lat     = 0;
      got_out = '0;
      got_c   = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat == 0) begin
               lat     = i;
               got_out = out;
               got_c   = flag_c;
            end
         end
         if (i == 2 || i == 5 || i == 12) start_go(OP_ADD, 8'd1, 8'd1);
         else go = 1'b0;
      end
      check("busy_go pulses", 32'(pulses), 32'(1));
      check("busy_go latency", 32'(lat), 32'(12));
      check("busy_go out", 32'(got_out), 32'(44));
      check("busy_go flag_c", 32'(got_c), 32'(1));
      check("busy_go idle", 32'(CS), 32'(0));

      // go held high: one result every 5 cycles
      @(negedge clk);
      start_go(OP_ADD, 8'd2, 8'd3);
      pulses = 0;
      lat    = 0;
      d2     = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat == 0) lat = i;
            else d2 = i;
         end
         if (i == 10) go = 1'b0;
      end
      @(negedge clk);
      check("b2b pulses", 32'(pulses), 32'(2));
      check("b2b first", 32'(lat), 32'(4));
      check("b2b second", 32'(d2), 32'(9));
      check("b2b out", 32'(out), 32'(5));
      check("b2b idle", 32'(busy), 32'(0));

      // reset during the third MUL cycle aborts without done or write-back
      @(negedge clk);
      start_go(OP_MUL, 8'd20, 8'd15);
      pulses = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         go = 1'b0;
         if (done) pulses++;
      end
      check("abort cs_mul", 32'(CS), 32'(3));
      rst = 1'b0;
      #1;
      check("abort out", 32'(out), 32'(0));
      check("abort busy", 32'(busy), 32'(0));
      check("abort cs", 32'(CS), 32'(0));
      check("abort flag_c", 32'(flag_c), 32'(0));
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort no_done", 32'(pulses), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      start_go(OP_ADD, 8'd1, 8'd1);
      finish_op("post_rst_add", 8'd2, 1'b0, 1'b0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calculator_param.md
CALCULATOR_PARAM -- requirements
Module: calculator_param

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8 (minimum 4), giving the operand and result width.
REQ-002 The block SHALL have a parameter SHW, default $clog2(WIDTH), giving the width of the shift-amount field.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port go, input, 1 bit: start request; it SHALL be sampled only in IDLE.
REQ-006 Port op, input, 3 bits: operation select; it SHALL be latched with go.
REQ-007 Port in1, input, WIDTH bits: operand A; it SHALL be latched with go.
REQ-008 Port in2, input, WIDTH bits: operand B; it SHALL be latched with go.
REQ-009 Port out, output, WIDTH bits: registered result; it SHALL hold until the next write-back.
REQ-010 Port flag_c, output, 1 bit: registered carry/borrow/overflow flag.
REQ-011 Port flag_z, output, 1 bit: registered zero flag.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: single-cycle pulse that marks out and the flags valid.
REQ-014 Port CS, output, 4 bits: current state code, for the 7-segment display.

Function
REQ-015 Op codes SHALL be:
- 000 ADD
- 001 SUB (A-B)
- 010 AND
- 011 OR
- 100 XOR
- 101 SHL (A << B[SHW-1:0])
- 110 SHR, logical (A >> B[SHW-1:0])
- 111 MUL
REQ-016 The FSM states and CS codes SHALL be IDLE=0, LOAD=1, EXEC=2, MUL=3, WB=4, DONE=5; the unused codes 6-15 SHALL go to IDLE.
REQ-017 In IDLE with go=1, the FSM SHALL move to LOAD and latch op/in1/in2 into registers A, B, OPR; with go=0 it SHALL stay in IDLE.
REQ-018 LOAD SHALL always move to EXEC.
REQ-019 In EXEC, for non-MUL ops, the ALU result SHALL be captured into the result register R and the FSM SHALL move to WB.
REQ-020 In EXEC, for MUL, the FSM SHALL clear the accumulator, load a counter with WIDTH, and move to MUL.
REQ-021 MUL SHALL be iterative shift-add, one multiplier bit per cycle, holding a 2*WIDTH-bit product.
REQ-022 MUL SHALL move to WB when the counter reaches 0, after exactly WIDTH cycles.
REQ-023 WB SHALL update out, flag_c and flag_z together, then move to DONE.
REQ-024 DONE SHALL assert done for one cycle, then move to IDLE.
REQ-025 Latency: done SHALL be high in the 4th cycle after the edge that samples go (non-MUL), or the (4+WIDTH)th cycle (MUL).
REQ-026 A go that arrives while busy=1 (including in DONE) SHALL be ignored and not queued; changes to op/in1/in2 while busy SHALL not affect the result.
REQ-027 Back-to-back operation: go held high SHALL restart from IDLE one cycle after DONE, giving one result per 5 (non-MUL) cycles.
REQ-028 flag_c SHALL be:
- ADD: the carry-out of the WIDTH+1-bit sum
- SUB: the borrow (A<B)
- MUL: 1 if the product's high WIDTH bits are nonzero
- all other ops: 0
REQ-029 The result SHALL be truncated to WIDTH bits: ADD/SUB wrap mod 2^WIDTH, and MUL returns the low half.
REQ-030 flag_z SHALL be 1 exactly when the written result equals 0.
REQ-031 For SHL/SHR, only B[SHW-1:0] SHALL be used; a shift of 0 returns A unchanged.

Reset
REQ-032 While rst=0, the FSM SHALL be in IDLE and out, flag_c, flag_z, busy, done, A, B, OPR, R, the accumulator and the counter SHALL all be 0; CS SHALL be 0.
REQ-033 Reset deassertion SHALL be the only exit from reset; the first go SHALL be accepted on the first clk edge with rst=1.
REQ-034 Reset asserted mid-operation (any state, including MUL) SHALL abort the operation with no done pulse and no write-back.

Structure
REQ-035 A shared package calc_pkg SHALL hold the op-code constants and the state encoding (an enum-equivalent of 4-bit localparams).
REQ-036 The combinational ALU plus the MUL iteration step SHALL be one sub-module, calc_alu (parameter WIDTH; outputs result, carry).
REQ-037 The FSM, the operand/result registers and the MUL counter SHALL live in calculator_param.

Verification (WIDTH=8)
REQ-038 ADD 200+100 -> out=44, flag_c=1, flag_z=0, done exactly 4 cycles after go is sampled.
REQ-039 SUB 5-5 -> out=0, flag_z=1, flag_c=0; SUB 3-5 -> out=254, flag_c=1.
REQ-040 MUL 20*15 -> out=44, flag_c=1, done at cycle 12; MUL 12*10 -> out=120, flag_c=0.
REQ-041 SHL 0x81 by in2=0x09 (shift 1) -> out=0x02; SHR 0x80 by 7 -> out=0x01.
REQ-042 go pulsed with new operands during EXEC/MUL/DONE -> ignored; out reflects the original operands; only one done pulse.
REQ-043 rst=0 during the 3rd MUL cycle -> out=0, busy=0, CS=0, no done pulse; the next ADD 1+1 after release -> out=2.
